// File: rtl/uart_rx.sv
// Oversampling UART receiver: start 0, WIDTH data bits LSB first, optional parity, one stop 1.
// Define UART_RX_MAJORITY_EN to vote 2-of-3 samples around each mid-bit point.
module uart_rx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [WIDTH-1:0]   P_DATA,
  output logic               DATA_VALID,
  output logic               PAR_ERR,
  output logic               STP_ERR
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PRESC_W-1:0] presc;
  logic               par_en_q;
  logic               par_typ_q;
  logic [WIDTH-1:0]   shreg;
  logic               par_bad;
  logic               stop_bad;

  logic [PRESC_W-1:0] presc_sel_c;
  logic [PRESC_W-1:0] half_c;
  logic               last_edge_c;
  logic               smp_rdy_c;
  logic               smp_val_c;
  logic               exp_par_c;

  // Unsupported ratios fall back to 8 so a frame can never stall.
  assign presc_sel_c = ((PRESCALE == PRESC_W'(16)) || (PRESCALE == PRESC_W'(32)))
                       ? PRESCALE : PRESC_W'(8);
  assign half_c      = presc >> 1;
  assign last_edge_c = (edge_cnt == (presc - PRESC_W'(1)));
  assign exp_par_c   = (^shreg) ^ par_typ_q;

`ifdef UART_RX_MAJORITY_EN
  logic s_a;
  logic s_b;

  // Early samples at P/2-1 and P/2; the vote completes with the live line at P/2+1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (edge_cnt == (half_c - PRESC_W'(1))) s_a <= RX_IN;
      if (edge_cnt == half_c)                 s_b <= RX_IN;
    end
  end

  assign smp_rdy_c = (edge_cnt == (half_c + PRESC_W'(1)));
  assign smp_val_c = (s_a & s_b) | (s_a & RX_IN) | (s_b & RX_IN);
`else
  assign smp_rdy_c = (edge_cnt == half_c);
  assign smp_val_c = RX_IN;
`endif

  // Frame FSM with registered outcome strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc      <= PRESC_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          // The detecting cycle is edge 0 of the start bit.
          if (!RX_IN) begin
            state     <= START;
            edge_cnt  <= PRESC_W'(1);
            bit_cnt   <= '0;
            presc     <= presc_sel_c;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
          end
        end
        START: begin
          if (smp_rdy_c && smp_val_c) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (last_edge_c) begin
            state    <= DATA;
            edge_cnt <= '0;
          end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
          end
        end
        DATA: begin
          if (smp_rdy_c) shreg[bit_cnt] <= smp_val_c;
          if (last_edge_c) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
          end
        end
        PARITY: begin
          if (smp_rdy_c) par_bad <= (smp_val_c != exp_par_c);
          if (last_edge_c) begin
            edge_cnt <= '0;
            state    <= STOP;
          end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
          end
        end
        STOP: begin
          if (smp_rdy_c) stop_bad <= !smp_val_c;
          if (last_edge_c) begin
            edge_cnt <= '0;
            state    <= IDLE;
            if (!par_bad && !stop_bad) begin
              P_DATA     <= shreg;
              DATA_VALID <= 1'b1;
            end else begin
              PAR_ERR <= par_bad;
              STP_ERR <= stop_bad;
            end
          end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are rendered to a per-cycle waveform and decoded
// by sampling that waveform at mid-bit points; outputs are compared on every falling edge.
module tb_uart_rx;

  localparam int W    = 8;
  localparam int MAXC = (2 + W + 1) * 32;
`ifdef UART_RX_MAJORITY_EN
  localparam int GLITCH_DATA = 8'h00;
`else
  localparam int GLITCH_DATA = 8'h08;
`endif

  logic         CLK      = 1'b0;
  logic         RST      = 1'b1;
  logic         RX_IN    = 1'b1;
  logic [5:0]   PRESCALE = 6'd8;
  logic         PAR_EN   = 1'b0;
  logic         PAR_TYP  = 1'b0;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_ERR;
  logic         STP_ERR;

  uart_rx #(.WIDTH(W), .PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           edge_n;
    bit           dv;
    bit           pe;
    bit           se;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    string nm;
    int    got;
    int    want;
  } pin_t;

  exp_t         exp_q[$];
  pin_t         pin_q[$];
  logic         wave [0:MAXC-1];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_pdata = '0;
  bit           finish_req = 1'b0;
  exp_t         cur;
  pin_t         pp;
  bit           edv, epe, ese;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int eff_presc(input int p);
    return (p == 16 || p == 32) ? p : 8;
  endfunction

  // Value of bit b of the rendered waveform as a receiver with ratio p decides it.
  function automatic bit sample_bit(input int b, input int p);
    int m;
    m = b * p + p / 2;
`ifdef UART_RX_MAJORITY_EN
    return (int'(wave[m-1]) + int'(wave[m]) + int'(wave[m+1])) >= 2;
`else
    return wave[m];
`endif
  endfunction

  function automatic exp_t decode(input int p, input bit pen, input bit ptyp);
    exp_t e;
    int   n;
    n = 2 + W + int'(pen);
    e.edge_n = 0;
    e.data = '0;
    for (int i = 0; i < W; i++) e.data[i] = sample_bit(1 + i, p);
    e.pe = pen && (sample_bit(1 + W, p) != ((^e.data) ^ ptyp));
    e.se = !sample_bit(n - 1, p);
    e.dv = !e.pe && !e.se;
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  // Single compare process: strobes and held word checked every cycle.
  always @(negedge CLK) begin
    edv = 1'b0; epe = 1'b0; ese = 1'b0;
    if (RST) begin
      exp_q.delete();
      exp_pdata = '0;
    end else if (exp_q.size() > 0 && exp_q[0].edge_n == cyc + 1) begin
      cur = exp_q.pop_front();
      edv = cur.dv; epe = cur.pe; ese = cur.se;
      if (cur.dv) exp_pdata = cur.data;
    end
    chk("DATA_VALID", int'(DATA_VALID), int'(edv));
    chk("PAR_ERR", int'(PAR_ERR), int'(epe));
    chk("STP_ERR", int'(STP_ERR), int'(ese));
    chk("P_DATA", int'(P_DATA), int'(exp_pdata));
    while (pin_q.size() > 0) begin
      pp = pin_q.pop_front();
      chk(pp.nm, pp.got, pp.want);
    end
    if (finish_req) begin
      chk("pending_outcomes", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; pin_lat > 0 also pins the model's latency, word and flags to literals.
  task automatic send_frame(input logic [W-1:0] d, input int presc_in, input bit pen,
                            input bit ptyp, input bit par_flip, input bit stop_v,
                            input int glitch_idx, input int abort_idx, input int pin_lat,
                            input int pin_data, input int pin_flags);
    int   p, n, total, b;
    exp_t e;
    logic par_v, v;
    p = eff_presc(presc_in);
    n = 2 + W + int'(pen);
    total = n * p;
    par_v = ((^d) ^ ptyp) ^ par_flip;
    for (int c = 0; c < total; c++) begin
      b = c / p;
      if (b == 0)                v = 1'b0;
      else if (b <= W)           v = d[b-1];
      else if (pen && b == W + 1) v = par_v;
      else                       v = stop_v;
      if (c == glitch_idx) v = ~v;
      wave[c] = v;
    end
    e = decode(p, pen, ptyp);
    for (int c = 0; c < total; c++) begin
      tick();
      if (c == abort_idx) return;
      if (c == 0) begin
        e.edge_n = cyc + 1 + total;
        exp_q.push_back(e);
        PRESCALE = 6'(presc_in);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (pin_lat > 0) begin
          pin_q.push_back('{"model_latency", total, pin_lat});
          pin_q.push_back('{"model_word", int'(e.data), pin_data});
          pin_q.push_back('{"model_flags", int'({e.dv, e.pe, e.se}), pin_flags});
        end
      end else if (c == 1) begin
        PRESCALE = 6'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
      RX_IN = wave[c];
    end
  endtask

  initial begin
    int sel, pv;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    idle(4);

    send_frame(8'hCB, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 88, 8'hCB, 3'b100);
    idle(3);
    send_frame(8'hCB, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 176, 8'hCB, 3'b010);
    idle(2);
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 320, 8'h5A, 3'b100);
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 320, 8'h3C, 3'b100);
    idle(2);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 80, 8'hFF, 3'b001);
    idle(2);
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 80, 8'h01, 3'b100);
    idle(2);

    // False start: two low cycles then idle.
    tick(); PRESCALE = 6'd16; RX_IN = 1'b0;
    tick(); RX_IN = 1'b0;
    idle(20);

    // One-cycle glitch at the mid point of data bit 3.
    send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, -1, 160, GLITCH_DATA, 3'b100);
    idle(2);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 4);
      pv = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : (sel == 3) ? 12
         : int'($urandom_range(0, 63));
      send_frame(8'($urandom), pv, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, -1, -1, 0, 0, 0);
      idle($urandom_range(0, 3));
    end

    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 80, 8'h96, 3'b100);
    idle(2);
    // Reset mid data bit 2, asserted between edges so only an asynchronous clear shows.
    send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 3 * 8 + 4, 0, 0, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    idle(5);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 88, 8'hA5, 3'b100);
    idle(20);
    finish_req = 1'b1;
    repeat (4) tick();
    $display("FAIL finish_not_reached cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the downstream partner of the system's UART transmitter, deserializing its frame format (start 0, WIDTH data bits LSB first, optional parity, one stop 1). It recovers each frame from the serial line using an oversampling prescaler and presents the parallel word with a one-cycle valid strobe. It flags parity and stop-bit errors to the register/control stage.

## Interface
- WIDTH, 8, data bits per frame
- PRESC_W, 6, width of PRESCALE input

- CLK  in  1  oversampling clock (PRESCALE × bit rate)
- RST  in  1  reset; one clock; asynchronous, active-high
- RX_IN  in  1  serial line, already synchronous to CLK, idle high
- PRESCALE  in  PRESC_W  oversampling ratio; legal 8, 16, 32; any other value is treated as 8
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  WIDTH  last good received word; holds until next good frame
- DATA_VALID  out  1  one-cycle strobe, P_DATA updated this cycle
- PAR_ERR  out  1  one-cycle strobe, parity mismatch in frame just ended
- STP_ERR  out  1  one-cycle strobe, stop bit sampled 0

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Edge counter counts 0..P-1 per bit; bit counter counts data bits 0..WIDTH-1.
- PRESCALE, PAR_EN, PAR_TYP captured in IDLE on start detection; changes mid-frame ignored.
- IDLE: RX_IN sampled 0 → START, edge count 0 = this cycle.
- Sample point: edge count P/2 (single sample, or majority per Configuration).
- START: sample 1 at the sample point → glitch, back to IDLE, no strobes. Sample 0 → at edge P-1 go DATA.
- DATA: shift sampled bit into bit position bit_cnt (LSB first); after bit WIDTH-1 ends → PARITY if PAR_EN else STOP.
- PARITY: compare sample with XOR of data (even) or its inverse (odd); latch mismatch.
- STOP: at end of stop bit (edge P-1) → IDLE; in the following cycle exactly one outcome:
  - no error: P_DATA ← shifted word, DATA_VALID = 1
  - parity mismatch: PAR_ERR = 1, P_DATA unchanged
  - stop sample 0: STP_ERR = 1, P_DATA unchanged (both error strobes may assert together)
- IDLE detection resumes in the same cycle the outcome strobe is driven; back-to-back frames with no idle gap are received.
- Reset (any time, incl. mid-frame): FSM → IDLE, counters 0, P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = 0; partial frame discarded.

## Timing
- Frame length N = 1 + WIDTH + PAR_EN + 1 bits.
- Outcome strobe is asserted N×P cycles after the clock edge that first sampled RX_IN low (P = captured prescale).
- All strobes exactly one cycle wide; no back-pressure; consumer must accept on the strobe.
- Outputs registered; no combinational path RX_IN → outputs.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit (start, data, parity, stop) is the 2-of-3 majority of samples at edge counts P/2-1, P/2, P/2+1. A single-cycle glitch at the mid-bit point is rejected.
- Undefined: single sample at edge count P/2; mid-bit glitch is taken as data.

## Test plan
- P=8, PAR_EN=1, PAR_TYP=0, send 0xCB (parity bit 1) → DATA_VALID one cycle at 88 cycles after start edge, P_DATA=0xCB, no error strobes.
- P=16, PAR_EN=1, PAR_TYP=1, send 0xCB with parity bit 1 (wrong; odd needs 0) → PAR_ERR one cycle, DATA_VALID stays 0, P_DATA keeps previous 0xCB.
- P=32, PAR_EN=0, send 0x5A then 0x3C back-to-back with no idle gap → two DATA_VALID strobes 320 cycles apart, P_DATA 0x5A then 0x3C.
- P=8, send 0xFF with stop bit 0 → STP_ERR one cycle, no DATA_VALID; the next clean frame 0x01 → DATA_VALID with P_DATA=0x01.
- RX_IN low for 2 cycles then high (P=16) → no strobes, FSM back in IDLE; with UART_RX_MAJORITY_EN, 1-cycle glitch at mid data bit of 0x00 → P_DATA=0x00.
- Assert RST mid-data-bit of a frame → all outputs 0 immediately; after release, a fresh 0xA5 frame is received correctly.
